// File: rtl/seq_div.sv
// seq_div: multi-cycle non-restoring integer divider, one quotient bit per clock.
// Signed operands are divided as magnitudes; signs are applied in the FIX cycle.
module seq_div #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero,
  output logic             ovf,
  output logic [1:0]       o_dbg_state
);

  // Handshake: start is sampled only while idle (busy low). Operands and mode are
  // captured on that edge; done pulses for one cycle with q/r/flags, which then hold.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_FIX = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state, w_next_state;
  logic [WIDTH:0]   r_pr;
  logic [WIDTH-1:0] r_quo, r_div, r_q, r_r;
  logic [CNT_W-1:0] r_cnt;
  logic             r_q_neg, r_r_neg, r_ovf_pend, r_done, r_dbz, r_ovf;

  logic             w_b_zero, w_a_neg, w_b_neg, w_ovf_det;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_quo_step, w_rem, w_q_fin, w_r_fin;
  logic [WIDTH:0]   w_pr_sh, w_pr_step;

  assign w_b_zero  = (b == '0);
  assign w_a_neg   = signed_op & a[WIDTH-1];
  assign w_b_neg   = signed_op & b[WIDTH-1];
  assign w_a_mag   = w_a_neg ? -a : a;
  assign w_b_mag   = w_b_neg ? -b : b;
  assign w_ovf_det = signed_op & (a == MOST_NEG) & (b == '1);

  // The sign of the partial remainder before the shift selects subtract or add.
  assign w_pr_sh    = {r_pr[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_pr_step  = r_pr[WIDTH] ? (w_pr_sh + {1'b0, r_div}) : (w_pr_sh - {1'b0, r_div});
  assign w_quo_step = {r_quo[WIDTH-2:0], ~w_pr_step[WIDTH]};

  assign w_rem   = r_pr[WIDTH] ? (r_pr[WIDTH-1:0] + r_div) : r_pr[WIDTH-1:0];
  assign w_q_fin = r_q_neg ? -r_quo : r_quo;
  assign w_r_fin = r_r_neg ? -w_rem : w_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start && !w_b_zero) w_next_state = S_ITER;
      S_ITER:  if (r_cnt == LAST_CNT) w_next_state = S_FIX;
      S_FIX:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pr       <= '0;
      r_quo      <= '0;
      r_div      <= '0;
      r_cnt      <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_done     <= 1'b0;
      r_q        <= '0;
      r_r        <= '0;
      r_dbz      <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_b_zero) begin
              r_done <= 1'b1;
              r_dbz  <= 1'b1;
              r_ovf  <= 1'b0;
              r_q    <= '1;
              r_r    <= '1;
            end else begin
              r_div      <= w_b_mag;
              r_quo      <= w_a_mag;
              r_pr       <= '0;
              r_cnt      <= '0;
              r_q_neg    <= w_a_neg ^ w_b_neg;
              r_r_neg    <= w_a_neg;
              r_ovf_pend <= w_ovf_det;
            end
          end
        end
        S_ITER: begin
          r_pr  <= w_pr_step;
          r_quo <= w_quo_step;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_FIX: begin
          r_pr   <= {1'b0, w_rem};
          r_done <= 1'b1;
          r_q    <= w_q_fin;
          r_r    <= w_r_fin;
          r_dbz  <= 1'b0;
          r_ovf  <= r_ovf_pend;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign q           = r_q;
  assign r           = r_r;
  assign div_by_zero = r_dbz;
  assign ovf         = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div: a 32-bit instance for the main scenarios and an
// 8-bit instance for a sweep against a behavioural reference.
module tb_seq_div;

  logic        clk, rst_n;
  logic        start32, sgn32, busy32, done32, dz32, ov32;
  logic [31:0] a32, b32, q32, r32;
  logic [1:0]  st32;
  logic        start8, sgn8, busy8, done8, dz8, ov8;
  logic [7:0]  a8, b8, q8, r8;
  logic [1:0]  st8;

  int n_checks = 0;
  int n_pass   = 0;

  seq_div #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .signed_op(sgn32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .q(q32), .r(r32), .div_by_zero(dz32), .ovf(ov32),
    .o_dbg_state(st32)
  );

  seq_div #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_op(sgn8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .q(q8), .r(r8), .div_by_zero(dz8), .ovf(ov8),
    .o_dbg_state(st8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one op on the 32-bit instance starting at the current time (just after
  // a rising edge). edges = rising edges after the start edge until done is seen;
  // a zero divisor completes on the start edge itself (edges = 0).
  task automatic run32(input logic sg, input logic [31:0] ta, input logic [31:0] tbv,
                       output int edges, output int bcnt);
    sgn32 = sg; a32 = ta; b32 = tbv; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    edges = 0;
    bcnt = busy32 ? 1 : 0;
    while (!done32 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (busy32) bcnt++;
    end
    if (!done32) begin
      n_checks++;
      $display("FAIL run32_timeout: done=%0b after %0d edges, required 1", done32, edges);
    end
  endtask

  task automatic run8(input logic sg, input logic [7:0] ta, input logic [7:0] tbv,
                      output int edges);
    sgn8 = sg; a8 = ta; b8 = tbv; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    edges = 0;
    while (!done8 && edges < 50) begin
      @(posedge clk); #1;
      edges++;
    end
    if (!done8) begin
      n_checks++;
      $display("FAIL run8_timeout: done=%0b after %0d edges, required 1", done8, edges);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
    start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy32, done32, dz32, ov32, q32, r32, st32} !== '0)
      $display("FAIL reset32: busy=%0b done=%0b dz=%0b ovf=%0b q=%h r=%h st=%0d, required all 0",
               busy32, done32, dz32, ov32, q32, r32, st32);
    else n_pass++;
    n_checks++;
    if ({busy8, done8, dz8, ov8, q8, r8, st8} !== '0)
      $display("FAIL reset8: busy=%0b done=%0b dz=%0b ovf=%0b q=%h r=%h, required all 0",
               busy8, done8, dz8, ov8, q8, r8);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    int e, bc;
    run32(1'b0, 32'd100, 32'd7, e, bc);
    n_checks++;
    if ({q32, r32, dz32, ov32} !== {32'd14, 32'd2, 2'b00})
      $display("FAIL unsigned_100_7: q=%0d r=%0d dz=%0b ovf=%0b, required q=14 r=2 flags 0",
               q32, r32, dz32, ov32);
    else n_pass++;
    n_checks++;
    if (e !== 33) $display("FAIL latency32: %0d edges, required 33", e);
    else n_pass++;
    n_checks++;
    if (bc !== 33) $display("FAIL busy_cycles32: %0d, required 33", bc);
    else n_pass++;
  endtask

  task automatic test_signed();
    int e, bc;
    run32(1'b1, -32'sd100, 32'd7, e, bc);
    n_checks++;
    if ({q32, r32, ov32} !== {32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0})
      $display("FAIL signed_m100_7: q=%h r=%h ovf=%0b, required q=fffffff2 r=fffffffe ovf=0",
               q32, r32, ov32);
    else n_pass++;
    run32(1'b1, 32'd100, -32'sd7, e, bc);
    n_checks++;
    if ({q32, r32, ov32} !== {32'hFFFF_FFF2, 32'd2, 1'b0})
      $display("FAIL signed_100_m7: q=%h r=%h ovf=%0b, required q=fffffff2 r=2 ovf=0",
               q32, r32, ov32);
    else n_pass++;
    // 4294967196 / 7 = 613566742 rem 2
    run32(1'b0, 32'hFFFF_FF9C, 32'd7, e, bc);
    n_checks++;
    if ({q32, r32, ov32} !== {32'h2492_4916, 32'd2, 1'b0})
      $display("FAIL unsigned_big: q=%h r=%h ovf=%0b, required q=24924916 r=2 ovf=0",
               q32, r32, ov32);
    else n_pass++;
  endtask

  task automatic test_div_zero();
    int e, bc;
    run32(1'b1, 32'h1234_5678, 32'd0, e, bc);
    n_checks++;
    if ({q32, r32, dz32, ov32} !== {32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10})
      $display("FAIL div_zero: q=%h r=%h dz=%0b ovf=%0b, required q=r=ffffffff dz=1 ovf=0",
               q32, r32, dz32, ov32);
    else n_pass++;
    n_checks++;
    if (e !== 0) $display("FAIL div_zero_latency: %0d edges after start edge, required 0", e);
    else n_pass++;
    run32(1'b0, 32'd9, 32'd3, e, bc);
    n_checks++;
    if ({q32, r32, dz32} !== {32'd3, 32'd0, 1'b0})
      $display("FAIL dz_clear: q=%0d r=%0d dz=%0b, required q=3 r=0 dz=0", q32, r32, dz32);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int e, bc;
    run32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, e, bc);
    n_checks++;
    if ({q32, r32, dz32, ov32, e} !== {32'h8000_0000, 32'd0, 2'b01, 32'd33})
      $display("FAIL signed_ovf: q=%h r=%h dz=%0b ovf=%0b edges=%0d, required q=80000000 r=0 ovf=1 edges=33",
               q32, r32, dz32, ov32, e);
    else n_pass++;
    run32(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, e, bc);
    n_checks++;
    if ({q32, r32, ov32} !== {32'd0, 32'h8000_0000, 1'b0})
      $display("FAIL unsigned_ovf_ops: q=%h r=%h ovf=%0b, required q=0 r=80000000 ovf=0",
               q32, r32, ov32);
    else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int cyc;
    sgn32 = 1'b0; a32 = 32'd1000; b32 = 32'd3; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    cyc = 0;
    while (!done32 && cyc < 100) begin
      if (cyc == 10) begin
        sgn32 = 1'b1; a32 = 32'd50; b32 = 32'd5; start32 = 1'b1;
      end else start32 = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start32 = 1'b0;
    n_checks++;
    if ({q32, r32, cyc} !== {32'd333, 32'd1, 32'd33})
      $display("FAIL busy_ignore: q=%0d r=%0d edges=%0d, required q=333 r=1 edges=33", q32, r32, cyc);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({busy32, done32} !== 2'b00)
      $display("FAIL busy_ignore_idle: busy=%0b done=%0b, required 0 0", busy32, done32);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int e, bc;
    run32(1'b0, 32'd8, 32'd3, e, bc);
    n_checks++;
    if ({q32, r32} !== {32'd2, 32'd2})
      $display("FAIL b2b_first: q=%0d r=%0d, required q=2 r=2", q32, r32);
    else n_pass++;
    // Start again while done is still high: a repeated done would show edges=0.
    run32(1'b1, -32'sd7, 32'd2, e, bc);
    n_checks++;
    if ({q32, r32, e} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd33})
      $display("FAIL b2b_second: q=%h r=%h edges=%0d, required q=fffffffd r=ffffffff edges=33",
               q32, r32, e);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    sgn32 = 1'b0; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (16) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy32, done32, dz32, ov32, q32, r32} !== '0)
      $display("FAIL reset_mid: busy=%0b done=%0b q=%h r=%h, required all 0", busy32, done32, q32, r32);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32 || busy32) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) $display("FAIL reset_mid_no_done: activity=%0b, required 0", saw_done);
    else n_pass++;
  endtask

  task automatic test_w8_sweep();
    int e, sa, sb, eq, er, ee;
    logic sg, edz, eov;
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      if (i == 0) begin sg = 1'b1; a8 = 8'h80; b8 = 8'hFF; end
      else if (i == 1) begin sg = 1'b0; a8 = 8'hFF; b8 = 8'h01; end
      else begin
        sg = 1'($urandom_range(0, 1));
        a8 = 8'($urandom_range(0, 255));
        b8 = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      end
      sa = sg ? int'($signed(a8)) : int'(a8);
      sb = sg ? int'($signed(b8)) : int'(b8);
      edz = 1'b0; eov = 1'b0; ee = 9;
      if (b8 == 8'h00) begin
        eq = -1; er = -1; edz = 1'b1; ee = 0;
      end else if (sg && a8 == 8'h80 && b8 == 8'hFF) begin
        eq = 32'h80; er = 0; eov = 1'b1;
      end else begin
        eq = sa / sb; er = sa % sb;
      end
      run8(sg, a8, b8, e);
      n_checks++;
      if ({q8, r8, dz8, ov8, e} !== {eq[7:0], er[7:0], edz, eov, ee}) begin
        if (bad < 10)
          $display("FAIL w8_op%0d: s=%0b a=%h b=%h got q=%h r=%h dz=%0b ovf=%0b edges=%0d, required q=%h r=%h dz=%0b ovf=%0b edges=%0d",
                   i, sg, a8, b8, q8, r8, dz8, ov8, e, eq[7:0], er[7:0], edz, eov, ee);
        bad++;
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_w8_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
